// File: rtl/dsp_sequencer_if.sv
// Bundle between the sequencer, its program ROM and the address-generator bank.
interface dsp_sequencer_if #(
  parameter int PROG_AW      = 8,
  parameter int NUM_GEN      = 3,
  parameter int OFFSET_WIDTH = 4
);
  localparam int IW = NUM_GEN * (4 + OFFSET_WIDTH) + 4;

  logic                            start;
  logic                            busy;
  logic                            done;
  logic                            err;
  logic [PROG_AW-1:0]              prog_addr;
  logic [IW-1:0]                   prog_data;
  logic [4*NUM_GEN-1:0]            addr_sel;
  logic [OFFSET_WIDTH*NUM_GEN-1:0] addr_ptr;
  logic                            series_inc;
  logic                            series_rst;

  modport master (
    input  start, prog_data,
    output busy, done, err, prog_addr, addr_sel, addr_ptr, series_inc, series_rst
  );

  modport slave (
    output start, prog_data,
    input  busy, done, err, prog_addr, addr_sel, addr_ptr, series_inc, series_rst
  );
endinterface

// File: rtl/dsp_sequencer.sv
// Program-driven sequencer feeding the addr_gen bank: fetches words from a
// fixed-latency ROM, executes them onto the generator lanes and runs a single
// hardware loop with a pipeline flush on the taken branch.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | fetching and executing program words
// S_DONE | halt executed, done pulse, back to idle next cycle
module dsp_sequencer #(
  parameter int PROG_AW      = 8,
  parameter int NUM_GEN      = 3,
  parameter int OFFSET_WIDTH = 4,
  parameter int ROM_LATENCY  = 2,
  parameter int SERIES_CNT   = 8
) (
  input logic              clk,
  input logic              rst,
  dsp_sequencer_if.master  bus
);
  localparam int IW   = NUM_GEN * (4 + OFFSET_WIDTH) + 4;
  localparam int L    = ROM_LATENCY;
  localparam int IT_W = (SERIES_CNT > 1) ? $clog2(SERIES_CNT) : 1;
  localparam logic [IT_W-1:0] ITER_LAST = IT_W'(SERIES_CNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [PROG_AW-1:0]              pc_q, loop_tgt_q;
  logic [IT_W-1:0]                 iter_q;
  logic                            err_q;
  // Entry 0 is the registered ROM address; entry L lines up with prog_data.
  logic [PROG_AW-1:0]              addr_pipe_q [0:L];
  logic [L:0]                      vld_q;
  logic [4*NUM_GEN-1:0]            sel_q, sel_d;
  logic [OFFSET_WIDTH*NUM_GEN-1:0] ptr_q, ptr_d;
  logic                            inc_q, srst_q;

  logic [IW-1:0]      word;
  logic               ex_vld, ex_halt, ex_srst, ex_loop, take_br, fetch_en;
  logic [PROG_AW-1:0] ex_addr, tgt_eff, fetch_addr;
  logic [IT_W-1:0]    iter_eff;

  assign bus.prog_addr  = addr_pipe_q[0];
  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = err_q;
  assign bus.addr_sel   = sel_q;
  assign bus.addr_ptr   = ptr_q;
  assign bus.series_inc = inc_q;
  assign bus.series_rst = srst_q;

  // Decode the word leaving the ROM pipe and decide the next fetch address.
  always_comb begin
    word     = bus.prog_data;
    ex_vld   = (state_q == S_RUN) && vld_q[L];
    ex_halt  = ex_vld && word[3];
    ex_srst  = ex_vld && word[1];
    ex_loop  = ex_vld && word[2] && !word[3];
    ex_addr  = addr_pipe_q[L];
    // A series_rst in the same word retargets the loop before loop_end is judged.
    tgt_eff  = ex_srst ? ex_addr + PROG_AW'(1) : loop_tgt_q;
    iter_eff = ex_srst ? '0 : iter_q;
    take_br  = ex_loop && (iter_eff != ITER_LAST);
    fetch_addr = take_br ? tgt_eff : pc_q;
    fetch_en   = (state_q == S_RUN) && !ex_halt;
  end

  // Split the instruction word into per-generator sel/ptr lanes.
  always_comb begin
    sel_d = '0;
    ptr_d = '0;
    for (int g = 0; g < NUM_GEN; g++) begin
      sel_d[4*g +: 4] = word[4 + g*(4+OFFSET_WIDTH) +: 4];
      ptr_d[OFFSET_WIDTH*g +: OFFSET_WIDTH] = word[8 + g*(4+OFFSET_WIDTH) +: OFFSET_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (ex_halt)   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch pointer, in-flight tags, loop bookkeeping and wrap error.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      loop_tgt_q <= '0;
      iter_q     <= '0;
      err_q      <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i <= L; i++) addr_pipe_q[i] <= '0;
    end else begin
      if (state_q == S_IDLE && bus.start) begin
        pc_q   <= '0;
        err_q  <= 1'b0;
      end else if (fetch_en) begin
        addr_pipe_q[0] <= fetch_addr;
        pc_q           <= fetch_addr + PROG_AW'(1);
        if (fetch_addr == '1) err_q <= 1'b1;
      end

      for (int i = 1; i <= L; i++) addr_pipe_q[i] <= addr_pipe_q[i-1];

      // A taken branch keeps only the redirected fetch; halt drops everything.
      if (!fetch_en)    vld_q <= '0;
      else if (take_br) vld_q <= {{L{1'b0}}, 1'b1};
      else              vld_q <= {vld_q[L-1:0], 1'b1};

      if (ex_srst) loop_tgt_q <= ex_addr + PROG_AW'(1);

      if (state_q == S_IDLE && bus.start) iter_q <= '0;
      else if (ex_loop)                    iter_q <= take_br ? iter_eff + IT_W'(1) : '0;
      else if (ex_srst)                    iter_q <= '0;
    end
  end

  // Executed fields go out one edge after the word emerges; bubbles drive zeros.
  always_ff @(posedge clk) begin
    if (rst || !ex_vld) begin
      sel_q  <= '0;
      ptr_q  <= '0;
      inc_q  <= 1'b0;
      srst_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
      inc_q  <= word[0];
      srst_q <= word[1];
    end
  end
endmodule

// File: tb/tb_dsp_sequencer.sv
module tb_dsp_sequencer;
  localparam int AW    = 4;
  localparam int NG    = 3;
  localparam int OW    = 4;
  localparam int L     = 2;
  localparam int CNT   = 8;
  localparam int IW    = NG * (4 + OW) + 4;
  localparam int DEPTH = 16;
  localparam int TMAX  = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsp_sequencer_if #(.PROG_AW(AW), .NUM_GEN(NG), .OFFSET_WIDTH(OW)) bus ();

  dsp_sequencer #(
    .PROG_AW(AW), .NUM_GEN(NG), .OFFSET_WIDTH(OW), .ROM_LATENCY(L), .SERIES_CNT(CNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Program ROM with ROM_LATENCY=2 register stages.
  logic [IW-1:0] rom [DEPTH];
  logic [IW-1:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= rom[bus.prog_addr];
    rd2 <= rd1;
  end
  assign bus.prog_data = rd2;

  // Program description: control bits {halt,loop_end,series_rst,series_inc}, lanes.
  logic [3:0]  p_ctl [DEPTH];
  logic [11:0] p_sel [DEPTH];
  logic [11:0] p_ptr [DEPTH];

  // Expected per-cycle vector {busy,done,err,series_rst,series_inc,sel,ptr}.
  logic [28:0] exp_v [TMAX];
  logic [28:0] obs   [TMAX];
  int          model_tgt;
  int          checks, errors;
  int          sinc_cnt, done_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] obs_vec();
    return {bus.busy, bus.done, bus.err, bus.series_rst, bus.series_inc, bus.addr_sel, bus.addr_ptr};
  endfunction

  task automatic load_rom();
    logic [IW-1:0] w;
    for (int a = 0; a < DEPTH; a++) begin
      w = '0;
      w[3:0] = p_ctl[a];
      for (int g = 0; g < NG; g++) begin
        w[4 + 8*g +: 4] = p_sel[a][4*g +: 4];
        w[8 + 8*g +: 4] = p_ptr[a][4*g +: 4];
      end
      rom[a] = w;
    end
  endtask

  task automatic clear_prog(input bit rnd_lanes);
    for (int a = 0; a < DEPTH; a++) begin
      p_ctl[a] = 4'b0000;
      p_sel[a] = rnd_lanes ? 12'($urandom) : 12'h000;
      p_ptr[a] = rnd_lanes ? 12'($urandom) : 12'h000;
    end
  endtask

  task automatic gen_rand();
    int h, r, e;
    clear_prog(1'b1);
    for (int a = 0; a < DEPTH; a++) p_ctl[a] = {3'b000, 1'($urandom_range(0, 1))};
    h = $urandom_range(2, 12);
    r = $urandom_range(0, h - 2);
    e = $urandom_range(r, h - 1);
    p_ctl[r][1] = 1'b1;
    p_ctl[e][2] = 1'b1;
    p_ctl[h][3] = 1'b1;
    if ($urandom_range(0, 3) == 0) p_ctl[h][2] = 1'b1;
    for (int a = h + 1; a < DEPTH; a++) p_ctl[a] = 4'($urandom);
    load_rom();
  endtask

  // Instruction-level walk of the program: one executed word per cycle,
  // a taken loop_end inserts ROM_LATENCY empty cycles before its target.
  task automatic build_exp(output int th);
    int t, pc, iter;
    for (int i = 0; i < TMAX; i++) exp_v[i] = '0;
    t = L + 2; pc = 0; iter = 0; th = 0;
    for (int s = 0; s < 400 && t < TMAX - 4; s++) begin
      exp_v[t][25]    = p_ctl[pc][1];
      exp_v[t][24]    = p_ctl[pc][0];
      exp_v[t][23:12] = p_sel[pc];
      exp_v[t][11:0]  = p_ptr[pc];
      if (p_ctl[pc][1]) begin model_tgt = (pc + 1) % DEPTH; iter = 0; end
      if (p_ctl[pc][3]) begin th = t; break; end
      if (p_ctl[pc][2] && iter < CNT - 1) begin
        iter++;
        pc = model_tgt;
        t += L + 1;
      end else begin
        if (p_ctl[pc][2]) iter = 0;
        pc = (pc + 1) % DEPTH;
        t++;
      end
    end
    for (int c = 0; c < th; c++) exp_v[c][28] = 1'b1;
    exp_v[th][27] = 1'b1;
  endtask

  // One run from the start-sampling edge (cycle 0) to one cycle after done.
  task automatic run_prog(input bit hold, input bit rnd_start);
    int th;
    build_exp(th);
    if (bus.start == 1'b0) begin
      @(negedge clk);
      bus.start = 1'b1;
    end
    @(posedge clk);
    sinc_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c <= th + 1; c++) begin
      @(negedge clk);
      if (c == th + 1) bus.start = hold;
      else if (hold)   bus.start = 1'b1;
      else             bus.start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      obs[c] = obs_vec();
      chk($sformatf("cyc%0d", c), obs[c], exp_v[c]);
      sinc_cnt += int'(obs[c][24]);
      done_cnt += int'(obs[c][27]);
    end
  endtask

  task automatic loop_prog();
    clear_prog(1'b1);
    p_ctl[0] = 4'b0010;
    p_ctl[1] = 4'b0001;
    p_ctl[2] = 4'b0100;
    p_ctl[3] = 4'b1000;
    load_rom();
  endtask

  initial begin
    bit seen;
    checks = 0; errors = 0; model_tgt = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    clear_prog(1'b0);
    load_rom();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", obs_vec(), 29'h0);
    chk("rst_paddr", bus.prog_addr, 0);
    rst = 1'b0;

    // Single instruction then halt.
    clear_prog(1'b0);
    p_sel[0] = 12'h001;
    p_ptr[0] = 12'h003;
    p_ctl[1] = 4'b1000;
    load_rom();
    run_prog(1'b0, 1'b0);
    chk("t1_sel", obs[4][23:12], 12'h001);
    chk("t1_ptr", obs[4][11:0], 12'h003);
    chk("t1_done", obs[5][27], 1);
    chk("t1_busy_after", obs[6][28], 0);
    chk("t1_done_cnt", done_cnt, 1);

    // Hardware loop, start toggling while busy.
    loop_prog();
    run_prog(1'b0, 1'b1);
    chk("t2_inc_cnt", sinc_cnt, CNT);
    chk("t2_done_cnt", done_cnt, 1);

    // halt|loop_end: no branch, trailing words never appear.
    clear_prog(1'b1);
    p_ctl[0] = 4'b0001;
    p_ctl[1] = 4'b1100;
    p_ctl[2] = 4'b0011;
    p_ctl[3] = 4'b0101;
    load_rom();
    run_prog(1'b0, 1'b0);
    chk("t3_done_cnt", done_cnt, 1);

    // PC wrap without halt; halt patched in on the second pass.
    clear_prog(1'b1);
    load_rom();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (c == 15) chk("t4_err_pre", bus.err, 0);
      if (c == 16) chk("t4_err_wrap", bus.err, 1);
      if (c == 18) begin
        p_ctl[5] = 4'b1000;
        load_rom();
      end
      if (bus.done) begin
        seen = 1'b1;
        chk("t4_err_done", bus.err, 1);
      end
    end
    chk("t4_done_seen", seen, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_err_idle", bus.err, 1);
    gen_rand();
    run_prog(1'b0, 1'b0);
    chk("t4_err_clr", obs[0][26], 0);

    // Reset in the third loop iteration, then a full replay.
    loop_prog();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    sinc_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 200 && sinc_cnt < 3; c++) begin
      @(negedge clk);
      sinc_cnt += int'(bus.series_inc);
      done_cnt += int'(bus.done);
    end
    chk("t5_reach", sinc_cnt, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_out", obs_vec(), 29'h0);
    chk("t5_paddr", bus.prog_addr, 0);
    chk("t5_no_done", done_cnt, 0);
    rst = 1'b0;
    model_tgt = 0;
    run_prog(1'b0, 1'b0);
    chk("t5_inc_cnt", sinc_cnt, CNT);
    chk("t5_done_cnt", done_cnt, 1);

    // start held high: back-to-back runs, one per idle entry.
    for (int k = 0; k < 3; k++) begin
      gen_rand();
      run_prog(k < 2, 1'b1);
      chk($sformatf("t6_done%0d", k), done_cnt, 1);
    end

    // Random programs.
    for (int k = 0; k < 12; k++) begin
      gen_rand();
      run_prog(1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
